// File: rtl/axi4_ram_responder_pkg.sv
// Shared types and helpers for the AXI4 RAM responder.
// FSM state encodings and the byte-offset shift helper.
package axi4_ram_responder_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rd_state_t;

    // LP_BYTE_SHIFT = log2 of bytes per beat
    function automatic int byte_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi4_ram_responder_if.sv
// Reduced AXI4 bus (AW/W/B/AR/R, no ID, INCR only).
// master: engine side; slave: RAM responder side.
interface axi4_ram_responder_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    import axi4_ram_responder_pkg::*;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              wlast;
    logic              bvalid;
    logic              bready;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic              rlast;

    modport master (
        output awvalid, awaddr, awlen,
        output wvalid, wdata, wstrb, wlast,
        output bready, arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, arready,
        input  rvalid, rdata, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen,
        input  wvalid, wdata, wstrb, wlast,
        input  bready, arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, arready,
        output rvalid, rdata, rlast
    );

endinterface

// File: rtl/axi4_ram_responder_bram.sv
// Simple dual-port RAM: byte-enable write port, registered read port, read-first.
// Ports: ap_clk, i_we/i_waddr/i_wdata/i_wstrb, i_re/i_raddr, o_rdata.
module axi4_ram_responder_bram
    import axi4_ram_responder_pkg::*;
#(
    parameter int C_DATA_WIDTH = 512,
    parameter int C_DEPTH      = 1024,
    parameter int C_IDX_W      = $clog2(C_DEPTH)
) (
    input  logic                      ap_clk,
    input  logic                      i_we,
    input  logic [C_IDX_W-1:0]        i_waddr,
    input  logic [C_DATA_WIDTH-1:0]   i_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                      i_re,
    input  logic [C_IDX_W-1:0]        i_raddr,
    output logic [C_DATA_WIDTH-1:0]   o_rdata
);

    logic [C_DATA_WIDTH-1:0] r_mem [C_DEPTH];
    logic [C_DATA_WIDTH-1:0] r_q;

    // Non-blocking read of the old word gives read-first on a collision
    always_ff @(posedge ap_clk) begin
        if (i_we) begin
            for (int b = 0; b < C_DATA_WIDTH / 8; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/axi4_ram_responder.sv
// AXI4 slave backed by on-chip RAM; independent read and write FSMs.
// Ports: ap_clk, areset (sync, high), s_axi bus, err_wlast/err_range sticky flags.
module axi4_ram_responder
    import axi4_ram_responder_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH_WORDS  = 1024,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
    input  logic ap_clk,
    input  logic areset,
    axi4_ram_responder_if.slave s_axi,
    output logic err_wlast,
    output logic err_range
);

    localparam int AW            = C_S_AXI_ADDR_WIDTH;
    localparam int DW            = C_S_AXI_DATA_WIDTH;
    localparam int LP_IDX_W      = $clog2(C_MEM_DEPTH_WORDS);
    localparam int LP_BYTE_SHIFT = byte_shift(DW);
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(C_MEM_DEPTH_WORDS);

    wr_state_t r_wstate, w_wstate_nxt;
    rd_state_t r_rstate, w_rstate_nxt;

    logic [LP_IDX_W-1:0] r_widx, r_ridx;
    logic [7:0]          r_wcnt, r_rcnt;
    logic [DW-1:0]       r_rdata;
    logic                r_err_wlast, r_err_range;

    logic w_awready, w_wready, w_bvalid;
    logic w_arready, w_rvalid, w_rlast;
    logic w_re;
    logic [LP_IDX_W-1:0] w_raddr;
    logic [DW-1:0]       w_q;

    // Address decode; a burst is out of range if its last word reaches depth
    logic [AW-1:0]       w_aw_word, w_ar_word;
    logic [AW:0]         w_aw_end, w_ar_end;
    logic                w_aw_oor, w_ar_oor;
    logic [LP_IDX_W-1:0] w_aw_idx, w_ar_idx;

    assign w_aw_word = (s_axi.awaddr - C_BASE_ADDR) >> LP_BYTE_SHIFT;
    assign w_ar_word = (s_axi.araddr - C_BASE_ADDR) >> LP_BYTE_SHIFT;
    assign w_aw_end  = {1'b0, w_aw_word} + {{(AW-7){1'b0}}, s_axi.awlen};
    assign w_ar_end  = {1'b0, w_ar_word} + {{(AW-7){1'b0}}, s_axi.arlen};
    assign w_aw_oor  = w_aw_end >= LP_DEPTH;
    assign w_ar_oor  = w_ar_end >= LP_DEPTH;
    assign w_aw_idx  = w_aw_word[LP_IDX_W-1:0];
    assign w_ar_idx  = w_ar_word[LP_IDX_W-1:0];

    logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    assign w_aw_hs = w_awready & s_axi.awvalid;
    assign w_w_hs  = w_wready  & s_axi.wvalid;
    assign w_ar_hs = w_arready & s_axi.arvalid;
    assign w_r_hs  = w_rvalid  & s_axi.rready;

    // Write FSM
    always_ff @(posedge ap_clk) begin
        if (areset) r_wstate <= W_IDLE;
        else        r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        if (!areset) begin
            unique case (r_wstate)
                W_IDLE: begin
                    w_awready = 1'b1;
                    if (s_axi.awvalid) w_wstate_nxt = W_DATA;
                end
                W_DATA: begin
                    w_wready = 1'b1;
                    if (s_axi.wvalid && r_wcnt == 8'd0) w_wstate_nxt = W_RESP;
                end
                W_RESP: begin
                    w_bvalid = 1'b1;
                    if (s_axi.bready) w_wstate_nxt = W_IDLE;
                end
                default: w_wstate_nxt = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_widx      <= '0;
            r_wcnt      <= '0;
            r_err_wlast <= 1'b0;
            r_err_range <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_widx <= w_aw_idx;
                r_wcnt <= s_axi.awlen;
            end
            if (w_w_hs) begin
                r_widx <= r_widx + 1'b1;
                r_wcnt <= r_wcnt - 8'd1;
                if (s_axi.wlast != (r_wcnt == 8'd0)) r_err_wlast <= 1'b1;
            end
            if ((w_aw_hs && w_aw_oor) || (w_ar_hs && w_ar_oor)) begin
                r_err_range <= 1'b1;
            end
        end
    end

    // Read FSM: RAM output always holds the beat after the one presented,
    // so each R handshake reloads rdata from it and fetches one further.
    always_ff @(posedge ap_clk) begin
        if (areset) r_rstate <= R_IDLE;
        else        r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        w_rlast      = 1'b0;
        w_re         = 1'b0;
        w_raddr      = r_ridx;
        if (!areset) begin
            unique case (r_rstate)
                R_IDLE: begin
                    w_arready = 1'b1;
                    w_raddr   = w_ar_idx;
                    if (s_axi.arvalid) begin
                        w_re         = 1'b1;
                        w_rstate_nxt = R_FETCH;
                    end
                end
                R_FETCH: begin
                    w_re         = 1'b1;
                    w_rstate_nxt = R_DATA;
                end
                R_DATA: begin
                    w_rvalid = 1'b1;
                    w_rlast  = (r_rcnt == 8'd0);
                    if (s_axi.rready) begin
                        if (r_rcnt == 8'd0) w_rstate_nxt = R_IDLE;
                        else                w_re = 1'b1;
                    end
                end
                default: w_rstate_nxt = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_ridx  <= '0;
            r_rcnt  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_ar_hs) begin
                r_ridx <= w_ar_idx + 1'b1;
                r_rcnt <= s_axi.arlen;
            end
            if (r_rstate == R_FETCH) begin
                r_rdata <= w_q;
                r_ridx  <= r_ridx + 1'b1;
            end
            if (w_r_hs && r_rcnt != 8'd0) begin
                r_rdata <= w_q;
                r_ridx  <= r_ridx + 1'b1;
                r_rcnt  <= r_rcnt - 8'd1;
            end
        end
    end

    axi4_ram_responder_bram #(
        .C_DATA_WIDTH (DW),
        .C_DEPTH      (C_MEM_DEPTH_WORDS),
        .C_IDX_W      (LP_IDX_W)
    ) u_bram (
        .ap_clk  (ap_clk),
        .i_we    (w_w_hs),
        .i_waddr (r_widx),
        .i_wdata (s_axi.wdata),
        .i_wstrb (s_axi.wstrb),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_q)
    );

    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.bvalid  = w_bvalid;
    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = w_rvalid;
    assign s_axi.rlast   = w_rlast;
    assign s_axi.rdata   = r_rdata;
    assign err_wlast     = r_err_wlast;
    assign err_range     = r_err_range;

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Scoreboard bench for axi4_ram_responder.
// Stimulus tasks push expected R beats / B tokens; a negedge monitor checks them.
module tb_axi4_ram_responder;

    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1024;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } rexp_t;

    logic ap_clk = 1'b0;
    logic areset = 1'b1;
    logic err_wlast, err_range;

    always #5 ap_clk = ~ap_clk;

    axi4_ram_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi4_ram_responder #(
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .C_MEM_DEPTH_WORDS  (DEPTH),
        .C_BASE_ADDR        ('0)
    ) dut (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .s_axi     (bus),
        .err_wlast (err_wlast),
        .err_range (err_range)
    );

    rexp_t         rq[$];
    logic [DW-1:0] model [int];
    int            checks = 0;
    int            errors = 0;
    int            b_pend = 0;
    bit            rrnd = 0, brnd = 0, rhold = 0;
    bit            stalled = 0;
    logic [DW-1:0] held;

    function automatic void chk(input string nm, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic void tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout got none want handshake", nm);
    endfunction

    // Monitor: R beats against the queue, B tokens against the pending count
    always @(negedge ap_clk) begin
        if (bus.rvalid) begin
            if (stalled) chk("r_stable", bus.rdata, held);
            if (bus.rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected got %0h want none", bus.rdata);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("rdata", bus.rdata, e.d);
                    chk("rlast", DW'(bus.rlast), DW'(e.l));
                end
                stalled = 0;
            end else begin
                stalled = 1;
                held    = bus.rdata;
            end
        end else begin
            stalled = 0;
        end
        if (bus.bvalid && bus.bready) begin
            checks++;
            if (b_pend == 0) begin
                errors++;
                $display("FAIL b_unexpected got bvalid want none");
            end else begin
                b_pend--;
            end
        end
    end

    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            bus.rready = rhold ? 1'b0 :
                         (rrnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got hang want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic bit rdy(input int w);
        case (w)
            0:       return bus.awready;
            1:       return bus.wready;
            default: return bus.arready;
        endcase
    endfunction

    task automatic wait_rdy(input int w, input string nm);
        int t = 0;
        @(negedge ap_clk);
        while (!rdy(w) && t < 200) begin
            @(negedge ap_clk);
            t++;
        end
        if (!rdy(w)) tmo(nm);
    endtask

    function automatic int widx(input logic [AW-1:0] addr, input int i);
        return int'(((addr >> 6) + AW'(i)) % DEPTH);
    endfunction

    function automatic void mwrite(input int idx, input logic [DW-1:0] d,
                                   input logic [SW-1:0] s);
        logic [DW-1:0] v;
        v = model.exists(idx) ? model[idx] : '0;
        for (int b = 0; b < SW; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        model[idx] = v;
    endfunction

    task automatic wait_b();
        int t = 0;
        while (b_pend != 0 && t < 300) begin
            tick();
            bus.bready = brnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge ap_clk);
            t++;
        end
        if (b_pend != 0) begin
            tmo("bresp");
            b_pend = 0;
        end
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] dq[$],
                            input logic [SW-1:0] strb, input int lastbeat);
        tick();
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.awlen   = 8'(dq.size() - 1);
        wait_rdy(0, "aw");
        tick();
        bus.awvalid = 1'b0;
        for (int i = 0; i < dq.size(); i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = dq[i];
            bus.wstrb  = strb;
            bus.wlast  = (i == lastbeat);
            wait_rdy(1, "w");
            mwrite(widx(addr, i), dq[i], strb);
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        b_pend++;
        wait_b();
    endtask

    task automatic issue_read(input logic [AW-1:0] addr, input logic [DW-1:0] dq[$],
                              input bit chklat);
        for (int i = 0; i < dq.size(); i++) rq.push_back('{dq[i], i == dq.size() - 1});
        tick();
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arlen   = 8'(dq.size() - 1);
        wait_rdy(2, "ar");
        tick();
        bus.arvalid = 1'b0;
        if (chklat) begin
            @(negedge ap_clk);
            chk("lat_fetch_rvalid", DW'(bus.rvalid), DW'(0));
            @(negedge ap_clk);
            chk("lat_data_rvalid", DW'(bus.rvalid), DW'(1));
        end
    endtask

    task automatic drain_r();
        int t = 0;
        while (rq.size() != 0 && t < 3000) begin
            @(negedge ap_clk);
            t++;
        end
        if (rq.size() != 0) begin
            tmo("rdrain");
            rq.delete();
        end
    endtask

    task automatic read_model(input logic [AW-1:0] addr, input int len);
        logic [DW-1:0] q[$];
        for (int i = 0; i <= len; i++) q.push_back(model[widx(addr, i)]);
        issue_read(addr, q, 0);
        drain_r();
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] ones;
        logic [DW-1:0] old_v, new_v;
        ones = '1;
        bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0;
        bus.wvalid  = 0; bus.wdata  = '0; bus.wstrb = '0; bus.wlast = 0;
        bus.bready  = 0; bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0;

        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_awready", DW'(bus.awready), DW'(0));
        chk("rst_arready", DW'(bus.arready), DW'(0));
        chk("rst_bvalid", DW'(bus.bvalid), DW'(0));
        chk("rst_rvalid", DW'(bus.rvalid), DW'(0));
        chk("rst_rlast", DW'(bus.rlast), DW'(0));
        chk("rst_rdata", bus.rdata, DW'(0));
        chk("rst_errs", DW'({err_wlast, err_range}), DW'(0));
        tick();
        areset = 1'b0;
        @(negedge ap_clk);
        chk("idle_awready", DW'(bus.awready), DW'(1));
        chk("idle_arready", DW'(bus.arready), DW'(1));

        // single beat write then read, with AR->R latency
        q = '{{64{8'hA5}}};
        do_write(64'h40, q, '1, 0);
        issue_read(64'h40, q, 1);
        drain_r();

        // 16-beat burst, rready held high
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(DW'(i));
        do_write(64'h0, q, '1, 15);
        issue_read(64'h0, q, 0);
        drain_r();

        // 256-beat burst under random R and B backpressure
        rrnd = 1; brnd = 1;
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back({16{32'hC0DE_0000 + 32'(i)}});
        do_write(64'(256 * 64), q, '1, 255);
        issue_read(64'(256 * 64), q, 0);
        drain_r();
        rrnd = 0; brnd = 0;

        // byte strobe
        q = '{ones};
        do_write(64'(40 * 64), q, '1, 0);
        q = '{DW'(0)};
        do_write(64'(40 * 64), q, SW'(1), 0);
        q = '{{{63{8'hFF}}, 8'h00}};
        issue_read(64'(40 * 64), q, 0);
        drain_r();
        @(negedge ap_clk);
        chk("no_err_range", DW'(err_range), DW'(0));
        chk("no_err_wlast", DW'(err_wlast), DW'(0));

        // wrap past the last word
        q = '{DW'(64'hD1D1), DW'(64'hD2D2)};
        do_write(64'(1023 * 64), q, '1, 1);
        @(negedge ap_clk);
        chk("err_range_set", DW'(err_range), DW'(1));
        q = '{DW'(64'hD2D2)};
        issue_read(64'h0, q, 0);
        drain_r();
        q = '{DW'(64'hD1D1)};
        issue_read(64'(1023 * 64), q, 0);
        drain_r();

        // early wlast: burst length still follows awlen
        q = '{DW'(11), DW'(22), DW'(33), DW'(44)};
        do_write(64'(100 * 64), q, '1, 0);
        @(negedge ap_clk);
        chk("err_wlast_set", DW'(err_wlast), DW'(1));
        issue_read(64'(100 * 64), q, 0);
        drain_r();

        // same-cycle read and write of word 5 returns the old word
        old_v = {8{64'h0123_4567_89AB_CDEF}};
        new_v = {8{64'hFEDC_BA98_7654_3210}};
        q = '{old_v};
        do_write(64'(5 * 64), q, '1, 0);
        tick();
        bus.awvalid = 1'b1;
        bus.awaddr  = 64'(5 * 64);
        bus.awlen   = 8'd0;
        wait_rdy(0, "aw_coll");
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b1;
        bus.wdata   = new_v;
        bus.wstrb   = '1;
        bus.wlast   = 1'b1;
        bus.arvalid = 1'b1;
        bus.araddr  = 64'(5 * 64);
        bus.arlen   = 8'd0;
        rq.push_back('{old_v, 1'b1});
        wait_rdy(1, "w_coll");
        chk("coll_arready", DW'(bus.arready), DW'(1));
        tick();
        bus.wvalid  = 1'b0;
        bus.wlast   = 1'b0;
        bus.arvalid = 1'b0;
        mwrite(5, new_v, '1);
        b_pend++;
        wait_b();
        drain_r();
        q = '{new_v};
        issue_read(64'(5 * 64), q, 0);
        drain_r();

        // reset in the middle of a stalled read burst
        rhold = 1;
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(model[i]);
        issue_read(64'h0, q, 0);
        repeat (4) @(negedge ap_clk);
        chk("stall_rvalid", DW'(bus.rvalid), DW'(1));
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        rq.delete();
        @(negedge ap_clk);
        chk("post_rst_rvalid", DW'(bus.rvalid), DW'(0));
        chk("post_rst_arready", DW'(bus.arready), DW'(1));
        chk("post_rst_err_range", DW'(err_range), DW'(0));
        rhold = 0;
        read_model(64'(3 * 64), 2);

        repeat (3) @(negedge ap_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
